ps2_kbd_event_ctrl: RTL

//  Sequences the PS/2 keyboard path: takes raw set-2 bytes from the PS/2 receiver, strips E0/F0/E1 prefixes,

---
 rtl/ps2_kbd_event_ctrl_if.sv | 33 +++
 rtl/ps2_kbd_event_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_event_ctrl_if.sv
// Bundle of PS/2 receiver, translator and CPU keyboard-port signals.
//   ps2_data/ps2_done : received byte + one-cycle strobe
//   at_code/xt_code   : scancode to the external translator and its result
//   rd/clr_ovf        : CPU pop request and overflow clear
//   key_*             : FIFO head event (first-word fall-through)
//   fifo_count/ovf    : queue occupancy and sticky lost-event flag
// Modports: master = environment side, slave = controller side.
interface ps2_kbd_event_ctrl_if #(
  parameter int unsigned FIFO_AW = 3
);
  logic [7:0]       ps2_data;
  logic             ps2_done;
  logic [7:0]       at_code;
  logic [7:0]       xt_code;
  logic             rd;
  logic             clr_ovf;
  logic             key_valid;
  logic [7:0]       key_ascii;
  logic             key_release;
  logic             key_ext;
  logic [FIFO_AW:0] fifo_count;
  logic             ovf;

  modport master (
    output ps2_data, ps2_done, xt_code, rd, clr_ovf,
    input  at_code, key_valid, key_ascii, key_release, key_ext, fifo_count, ovf
  );

  modport slave (
    input  ps2_data, ps2_done, xt_code, rd, clr_ovf,
    output at_code, key_valid, key_ascii, key_release, key_ext, fifo_count, ovf
  );
endinterface

// File: rtl/ps2_kbd_event_ctrl.sv
// PS/2 keyboard event sequencer: strips E0/F0/E1 prefixes from set-2 bytes,
// drives the external AT->ASCII translator and queues {ext,rel,code} events
// in a first-word-fall-through FIFO popped by the CPU.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of ps2_kbd_event_ctrl_if (receiver, translator, CPU)
module ps2_kbd_event_ctrl #(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ps2_kbd_event_ctrl_if.slave   bus
);

  localparam int unsigned DEPTH    = 1 << FIFO_AW;
  localparam int unsigned CW       = FIFO_AW + 1;
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam int unsigned SW       = 3;
  localparam int unsigned SKIP_LEN = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PFX    = 2'd1,
    SKIP   = 2'd2,
    LOOKUP = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  state_t             state,    state_n;
  logic               ext_q,    ext_n;
  logic               rel_q,    rel_n;
  logic [SW-1:0]      skip_cnt, skip_cnt_n;
  logic [TW-1:0]      timer,    timer_n;
  logic [7:0]         at_code,  at_code_n;
  logic [FIFO_AW-1:0] wr_ptr,   wr_ptr_n;
  logic [FIFO_AW-1:0] rd_ptr,   rd_ptr_n;
  logic [CW-1:0]      count,    count_n;
  logic               ovf_q,    ovf_n;

  logic               full;
  logic               pop;
  logic               push;
  logic               ovf_set;
  logic               timeout;
  key_event_t         wr_event;
  key_event_t         head;
  key_event_t         mem [DEPTH];

  assign full    = (count == CW'(DEPTH));
  assign pop     = bus.rd && (count != '0);
  assign timeout = (timer == TW'(TIMEOUT - 1));

  // State register and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      skip_cnt <= '0;
      timer    <= '0;
      at_code  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      ext_q    <= ext_n;
      rel_q    <= rel_n;
      skip_cnt <= skip_cnt_n;
      timer    <= timer_n;
      at_code  <= at_code_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      ovf_q    <= ovf_n;
    end
  end

  // Next-state, prefix tracking and FIFO control
  always_comb begin
    state_n    = state;
    ext_n      = ext_q;
    rel_n      = rel_q;
    skip_cnt_n = skip_cnt;
    timer_n    = timer;
    at_code_n  = at_code;
    push       = 1'b0;
    ovf_set    = 1'b0;

    unique case (state)
      IDLE, PFX: begin
        if (bus.ps2_done) begin
          case (bus.ps2_data)
            8'hE0: begin
              ext_n   = 1'b1;
              timer_n = '0;
              state_n = PFX;
            end
            8'hF0: begin
              rel_n   = 1'b1;
              timer_n = '0;
              state_n = PFX;
            end
            8'hE1: begin
              skip_cnt_n = SW'(SKIP_LEN);
              timer_n    = '0;
              state_n    = SKIP;
            end
            default: begin
              at_code_n = bus.ps2_data;
              state_n   = LOOKUP;
            end
          endcase
        end else if (state == PFX) begin
          if (timeout) begin
            ext_n   = 1'b0;
            rel_n   = 1'b0;
            timer_n = '0;
            state_n = IDLE;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      end

      SKIP: begin
        // Pause key: swallow the remaining bytes of the E1 sequence
        if (bus.ps2_done) begin
          timer_n    = '0;
          skip_cnt_n = skip_cnt - SW'(1);
          if (skip_cnt == SW'(1)) begin
            ext_n   = 1'b0;
            rel_n   = 1'b0;
            state_n = IDLE;
          end
        end else if (timeout) begin
          ext_n      = 1'b0;
          rel_n      = 1'b0;
          skip_cnt_n = '0;
          timer_n    = '0;
          state_n    = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      LOOKUP: begin
        // A byte arriving now cannot be sequenced and is lost
        if (bus.ps2_done) begin
          ovf_set = 1'b1;
        end
        // A same-cycle pop frees the slot, so a full FIFO still accepts
        if (!full || pop) begin
          push = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
        ext_n   = 1'b0;
        rel_n   = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    wr_ptr_n = wr_ptr + FIFO_AW'(push);
    rd_ptr_n = rd_ptr + FIFO_AW'(pop);

    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase

    // Set wins over clear
    if (ovf_set) begin
      ovf_n = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_n = 1'b0;
    end else begin
      ovf_n = ovf_q;
    end
  end

  assign wr_event = '{ext: ext_q, rel: rel_q, code: bus.xt_code};

  // Event storage; contents are masked at the outputs while empty
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_event;
    end
  end

  assign head = mem[rd_ptr];

  assign bus.at_code     = at_code;
  assign bus.key_valid   = (count != '0);
  assign bus.key_ascii   = bus.key_valid ? head.code : 8'h00;
  assign bus.key_release = bus.key_valid & head.rel;
  assign bus.key_ext     = bus.key_valid & head.ext;
  assign bus.fifo_count  = count;
  assign bus.ovf         = ovf_q;

endmodule
